// File: rtl/sar_search_pkg.sv
// Shared types and constants for the sar_search binary-search controller.
package sar_search_pkg;

  localparam int SAR_W      = 4;
  localparam int MAX_PROBES = SAR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Comparator response codes, ordered {e, g, l}.
  localparam logic [2:0] CMP_EQ = 3'b100;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/sar_search_mid.sv
// Next-bound / next-guess calculator for one binary-search probe.
module sar_search_mid
  import sar_search_pkg::*;
#(
  parameter int W = SAR_W
) (
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] guess,
  input  logic [2:0]   cmp,
  output logic [W-1:0] next_lo,
  output logic [W-1:0] next_hi,
  output logic [W-1:0] next_guess,
  output logic         inconsistent
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] gm1;
  logic [W-1:0] gp1;
  logic [W-1:0] span_gt;
  logic [W-1:0] span_lt;

  // Midpoint always as base + (span >> 1); guards keep spans non-negative.
  assign gm1     = guess - ONE;
  assign gp1     = guess + ONE;
  assign span_gt = gm1 - lo;
  assign span_lt = hi - gp1;

  always_comb begin
    next_lo      = lo;
    next_hi      = hi;
    next_guess   = guess;
    inconsistent = 1'b0;
    case (cmp)
      CMP_EQ: ;
      CMP_GT: begin
        if (guess == lo) begin
          inconsistent = 1'b1;
        end else begin
          next_hi    = gm1;
          next_guess = lo + (span_gt >> 1);
        end
      end
      CMP_LT: begin
        if (guess == hi) begin
          inconsistent = 1'b1;
        end else begin
          next_lo    = gp1;
          next_guess = gp1 + (span_lt >> 1);
        end
      end
      default: inconsistent = 1'b1;
    endcase
  end

endmodule

// File: rtl/sar_search.sv
// Binary-search controller driving a magnitude comparator's "a" operand.
// Optional probe counter output "steps" enabled by SAR_SEARCH_STEPCNT_EN.
//   state   | meaning
//   S_IDLE  | waiting for start; found/err/result hold
//   S_PROBE | guess presented, comparator response sampled at cycle end
//   S_DONE  | one-cycle done pulse, then back to idle
module sar_search
  import sar_search_pkg::*;
#(
  parameter int W = SAR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_e,
  input  logic         cmp_g,
  input  logic         cmp_l,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
`ifdef SAR_SEARCH_STEPCNT_EN
  output logic [W-1:0] result,
  output logic [$clog2(W+2)-1:0] steps
`else
  output logic [W-1:0] result
`endif
);

  state_e       state_q, state_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] guess_q, guess_d;
  logic         found_q, found_d;
  logic         err_q, err_d;
  logic [W-1:0] result_q, result_d;

  logic [2:0]   cmp_code;
  logic [W-1:0] mid_lo, mid_hi, mid_guess;
  logic         mid_bad;

  assign cmp_code = {cmp_e, cmp_g, cmp_l};

  sar_search_mid #(.W(W)) u_mid (
    .lo           (lo_q),
    .hi           (hi_q),
    .guess        (guess_q),
    .cmp          (cmp_code),
    .next_lo      (mid_lo),
    .next_hi      (mid_hi),
    .next_guess   (mid_guess),
    .inconsistent (mid_bad)
  );

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          guess_d  = {1'b0, {(W-1){1'b1}}};
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_PROBE;
        end
      end
      S_PROBE: begin
        if (cmp_code == CMP_EQ) begin
          found_d  = 1'b1;
          result_d = guess_q;
          state_d  = S_DONE;
        end else if (mid_bad) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          lo_d    = mid_lo;
          hi_d    = mid_hi;
          guess_d = mid_guess;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      guess_q  <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

`ifdef SAR_SEARCH_STEPCNT_EN
  localparam int STEP_W = $clog2(W+2);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  logic [STEP_W-1:0] steps_q, steps_d;

  always_comb begin
    steps_d = steps_q;
    if (state_q == S_IDLE && start) begin
      steps_d = '0;
    end else if (state_q == S_PROBE) begin
      steps_d = steps_q + STEP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      steps_q <= '0;
    end else begin
      steps_q <= steps_d;
    end
  end

  assign steps = steps_q;
`endif

  assign guess  = guess_q;
  assign busy   = (state_q == S_PROBE) || (state_q == S_DONE);
  assign done   = (state_q == S_DONE);
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search with a behavioural comparator and search model.
module tb_sar_search;
  import sar_search_pkg::*;

  typedef struct {
    bit found;
    bit err;
    int result;
    int probes;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cmp_e, cmp_g, cmp_l;
  logic [3:0] guess;
  logic       busy, done, found, err;
  logic [3:0] result;
`ifdef SAR_SEARCH_STEPCNT_EN
  logic [2:0] steps;
`endif

  logic [3:0] target;
  int         force_mode;   // 0 real comparator, 1 forced e+g, 2 forced g

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   guess_q[$];
  exp_t last_exp;
  int   probe_cnt = 0;

  sar_search #(.W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_e  (cmp_e),
    .cmp_g  (cmp_g),
    .cmp_l  (cmp_l),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .err    (err),
`ifdef SAR_SEARCH_STEPCNT_EN
    .result (result),
    .steps  (steps)
`else
    .result (result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: b operand is the target, a operand is the DUT's guess.
  always_comb begin
    cmp_e = (guess == target);
    cmp_g = (guess > target);
    cmp_l = (guess < target);
    if (force_mode == 1) begin
      cmp_e = 1'b1; cmp_g = 1'b1; cmp_l = 1'b0;
    end else if (force_mode == 2) begin
      cmp_e = 1'b0; cmp_g = 1'b1; cmp_l = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: plain integer binary search over 0..15 driven by the comparator rule.
  task automatic issue(input int tgt, input int mode);
    int   lo = 0;
    int   hi = 15;
    int   g;
    bit   fin = 0;
    exp_t e;
    e.found = 0; e.err = 0; e.result = 0; e.probes = 0;
    while (!fin) begin
      g = (lo + hi) / 2;
      guess_q.push_back(g);
      e.probes++;
      if (mode == 1) begin
        e.err = 1; fin = 1;
      end else if (mode == 0 && g == tgt) begin
        e.found = 1; e.result = g; fin = 1;
      end else if (mode == 2 || g > tgt) begin
        if (g == lo) begin e.err = 1; fin = 1; end
        else hi = g - 1;
      end else begin
        if (g == hi) begin e.err = 1; fin = 1; end
        else lo = g + 1;
      end
    end
    exp_q.push_back(e);
    last_exp = e;
  endtask

  // Monitor: checks every probe's guess and every completed search.
  always @(negedge clk) begin
    if (!rst_n) begin
      probe_cnt = 0;
      exp_q.delete();
      guess_q.delete();
    end else begin
      if (found && err) chk("found_and_err", 1, 0);
      if (busy && !done) begin
        probe_cnt++;
        if (guess_q.size() == 0) chk("unexpected_probe", 1, 0);
        else chk("guess", int'(guess), guess_q.pop_front());
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("found", int'(found), int'(e.found));
          chk("err", int'(err), int'(e.err));
          chk("result", int'(result), e.result);
          chk("probe_count", probe_cnt, e.probes);
`ifdef SAR_SEARCH_STEPCNT_EN
          chk("steps", int'(steps), e.probes);
`endif
        end
        if (guess_q.size() != 0) chk("leftover_guesses", guess_q.size(), 0);
        guess_q.delete();
        probe_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_search(input int tgt, input int mode, input bit pulse_busy);
    int  n = 0;
    bit  seen = 0;
    wait_idle();
    target     = 4'(tgt);
    force_mode = mode;
    start      = 1'b1;
    issue(tgt, mode);
    @(negedge clk);
    start = 1'b0;
    if (pulse_busy) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
    end
    while (!seen && n < 2 * MAX_PROBES + 6) begin
      @(negedge clk);
      if (done) seen = 1;
      n++;
    end
    if (!seen) chk("done_timeout", 1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_found", int'(found), int'(last_exp.found));
    chk("hold_err", int'(err), int'(last_exp.err));
    chk("hold_result", int'(result), last_exp.result);
    force_mode = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_guess"}, int'(guess), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_result"}, int'(result), 0);
`ifdef SAR_SEARCH_STEPCNT_EN
    chk({tag, "_steps"}, int'(steps), 0);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    target     = 4'd0;
    force_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_search(5, 0, 1'b0);
    run_search(15, 0, 1'b0);
    run_search(0, 0, 1'b0);
    run_search(0, 1, 1'b0);
    run_search(0, 2, 1'b1);

    // Abort a target-9 search during its second probe.
    wait_idle();
    target = 4'd9;
    start  = 1'b1;
    issue(9, 0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_search(9, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_search(int'($urandom_range(0, 15)), 0, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    if (exp_q.size() != 0) chk("pending_results", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
